// File: rtl/bird_motion_ctrl.sv
// bird_motion_ctrl: per-bird motion, hit and life-cycle controller.
// Position is held in signed fixed point and advanced once per frame tick.
module bird_motion_ctrl #(
    parameter int RANDOM_OFFSET    = 0,
    parameter int INITIAL_X        = 280,
    parameter int INITIAL_Y        = 185,
    parameter int IMAGE_WIDTH      = 32,
    parameter int IMAGE_HEIGHT     = 32,
    parameter int SCREEN_WIDTH     = 640,
    parameter int Y_MIN            = 0,
    parameter int Y_MAX            = 240,
    parameter int VERTICAL_EN      = 1,
    parameter int FRAC_BITS        = 6,
    parameter int BASE_STEP        = 50,
    parameter int STEP_INC         = 20,
    parameter int CHANCE_TO_CHANGE = 8,
    parameter int RED_FRAMES       = 32,
    parameter int WING_FRAMES      = 8,
    parameter int LIFE_W           = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     startOfFrame,
    input  logic                     deploy,
    input  logic                     collision,
    input  logic [7:0]               random,
    input  logic [LIFE_W-1:0]        starting_life,
    input  logic [1:0]               speed,
    output logic                     alive,
    output logic                     red,
    output logic                     wing,
    output logic [1:0]               direction,
    output logic signed [1:0][10:0]  coordinate
);

    typedef enum logic [2:0] {IDLE, HOVER, RIGHT, LEFT, DYING} state_t;

    localparam int RW = $clog2(RED_FRAMES + 1);
    localparam int WW = (WING_FRAMES > 1) ? $clog2(WING_FRAMES) : 1;
    localparam int ONE = 2 ** FRAC_BITS;

    localparam logic signed [31:0] X_HI   = 32'((SCREEN_WIDTH - IMAGE_WIDTH) * ONE);
    localparam logic signed [31:0] X_INIT = 32'(INITIAL_X * ONE);
    localparam logic signed [31:0] Y_INIT = 32'(INITIAL_Y * ONE);
    localparam logic signed [31:0] Y_LO   = 32'(Y_MIN * ONE);
    localparam logic signed [31:0] Y_HI   = 32'(Y_MAX * ONE);

    localparam logic [8:0]    CH        = 9'(CHANCE_TO_CHANGE);
    localparam logic [8:0]    CH_HALF   = 9'(CHANCE_TO_CHANGE / 2);
    localparam logic [RW-1:0] RED_LOAD  = RW'(RED_FRAMES);
    localparam logic [WW-1:0] WING_LAST = WW'(WING_FRAMES - 1);

    state_t               state;
    state_t               dir_st;
    state_t               nxt_dir;
    logic signed [31:0]   x;
    logic signed [31:0]   y;
    logic signed [31:0]   step;
    logic signed [31:0]   ystep;
    logic signed [31:0]   x_nx;
    logic signed [31:0]   y_nx;
    logic                 y_up;
    logic                 y_up_nx;
    logic [LIFE_W-1:0]    life;
    logic [LIFE_W-1:0]    life_dec;
    logic [RW-1:0]        red_cnt;
    logic [RW-1:0]        red_dec;
    logic [WW-1:0]        fcnt;
    logic                 latch;
    logic                 hit;
    logic [7:0]           r;
    logic [1:0]           code;

    always_comb begin
        r        = random + 8'(RANDOM_OFFSET);
        step     = 32'(BASE_STEP + STEP_INC * int'(speed));
        ystep    = step >>> 1;
        hit      = latch | (collision & (red_cnt == '0));
        red_dec  = (red_cnt == '0) ? '0 : red_cnt - RW'(1);
        life_dec = (life == '0) ? '0 : life - LIFE_W'(1);

        // a hit suppresses the random direction change for that frame
        dir_st = state;
        if (!hit && ({1'b0, r} < CH)) begin
            if (state == HOVER)
                dir_st = ({1'b0, r} < CH_HALF) ? RIGHT : LEFT;
            else
                dir_st = HOVER;
        end

        nxt_dir = dir_st;
        x_nx    = x;
        if (dir_st == RIGHT) begin
            x_nx = x + step;
            if (x_nx >= X_HI) begin
                x_nx    = X_HI;
                nxt_dir = LEFT;
            end
        end else if (dir_st == LEFT) begin
            x_nx = x - step;
            if (x_nx <= 0) begin
                x_nx    = '0;
                nxt_dir = RIGHT;
            end
        end

        y_nx    = y;
        y_up_nx = y_up;
        if (VERTICAL_EN != 0) begin
            if (y_up) begin
                y_nx = y - ystep;
                if (y_nx <= Y_LO) begin
                    y_nx    = Y_LO;
                    y_up_nx = 1'b0;
                end
            end else begin
                y_nx = y + ystep;
                if (y_nx >= Y_HI) begin
                    y_nx    = Y_HI;
                    y_up_nx = 1'b1;
                end
            end
        end

        code = (nxt_dir == RIGHT) ? 2'd1 :
               (nxt_dir == LEFT)  ? 2'd2 : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            x         <= X_INIT;
            y         <= Y_INIT;
            y_up      <= 1'b0;
            life      <= '0;
            red_cnt   <= '0;
            wing      <= 1'b0;
            latch     <= 1'b0;
            fcnt      <= '0;
            direction <= 2'd0;
        end else begin
            if (startOfFrame)
                fcnt <= (fcnt == WING_LAST) ? '0 : fcnt + WW'(1);

            unique case (state)
                IDLE: begin
                    latch <= 1'b0;
                    if (deploy && starting_life != '0) begin
                        state     <= HOVER;
                        life      <= starting_life;
                        x         <= X_INIT;
                        y         <= Y_INIT;
                        y_up      <= 1'b0;
                        red_cnt   <= '0;
                        direction <= 2'd0;
                    end
                end
                HOVER, RIGHT, LEFT: begin
                    if (startOfFrame) begin
                        latch   <= 1'b0;
                        red_cnt <= red_dec;
                        if (hit) begin
                            life    <= life_dec;
                            red_cnt <= RED_LOAD;
                        end
                        if (hit && life_dec == '0) begin
                            state <= DYING;
                        end else begin
                            state     <= nxt_dir;
                            direction <= code;
                            x         <= x_nx;
                            y         <= y_nx;
                            y_up      <= y_up_nx;
                            if (fcnt == WING_LAST)
                                wing <= ~wing;
                        end
                    end else if (collision && red_cnt == '0) begin
                        latch <= 1'b1;
                    end
                end
                DYING: begin
                    if (startOfFrame) begin
                        red_cnt <= red_dec;
                        if (red_cnt <= RW'(1)) begin
                            state     <= IDLE;
                            direction <= 2'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alive         = (state != IDLE);
    assign red           = (red_cnt != '0);
    assign coordinate[0] = x[FRAC_BITS+10:FRAC_BITS];
    assign coordinate[1] = y[FRAC_BITS+10:FRAC_BITS];

endmodule

// File: doc/bird_motion_ctrl.md
# bird_motion_ctrl

Per-enemy motion and life controller, second generation of the bird logic: one instance per bird, driven by the frame tick, feeding the bird draw/collision blocks. Adds parametrised screen and sprite geometry, vertical bobbing, wall bounce, wing-flap animation, collision latching with post-hit invulnerability, and an explicit deploy/dying/idle life cycle.

## Interface
- RANDOM_OFFSET, 0, added to random (mod 256) so instances sharing one generator diverge
- INITIAL_X / INITIAL_Y, 280 / 185, spawn top-left pixel
- IMAGE_WIDTH / IMAGE_HEIGHT, 32 / 32, sprite size
- SCREEN_WIDTH, 640, x range is 0..SCREEN_WIDTH-IMAGE_WIDTH
- Y_MIN / Y_MAX, 0 / 240, vertical band for top-left y
- VERTICAL_EN, 1, 0 disables vertical motion (y held at INITIAL_Y)
- FRAC_BITS, 6, fixed-point fraction bits
- BASE_STEP / STEP_INC, 50 / 20, step = BASE_STEP + STEP_INC*speed, in 1/2^FRAC_BITS pixel
- CHANCE_TO_CHANGE, 8, direction-change threshold on random
- RED_FRAMES, 32, flash length in frames
- WING_FRAMES, 8, frames per wing-flap phase
- LIFE_W, 4, life counter width
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- startOfFrame  in  1  one-cycle frame tick
- deploy  in  1  spawn request
- collision  in  1  shot hit, any cycle
- random  in  8  random byte
- starting_life  in  LIFE_W  lives loaded on deploy
- speed  in  2  speed level 0..3
- alive  out  1  bird drawn/collidable
- red  out  1  hit-flash active
- wing  out  1  0 wings up, 1 wings down
- direction  out  2  0 hover, 1 right, 2 left
- coordinate  out  signed [1:0][10:0]  [0]=x, [1]=y top-left pixel

## Operation
- States: IDLE, HOVER, RIGHT, LEFT, DYING. Reset: IDLE, x=INITIAL_X, y=INITIAL_Y (fixed-point), life=0, red counter=0, wing=0, collision latch=0, y direction=down. Resulting outputs: alive=0, red=0, wing=0, direction=0, coordinate=(INITIAL_X, INITIAL_Y).
- r = (random + RANDOM_OFFSET) mod 256, evaluated on the tick.
- IDLE: deploy=1 with starting_life≠0 -> HOVER at next edge, life=starting_life, position reset to spawn, red=0; deploy with starting_life=0 ignored. Collisions ignored, latch held clear. deploy in any other state ignored.
- Collision latch: set by collision in any cycle of HOVER/RIGHT/LEFT while red counter=0; cleared on each tick. Multiple hits per frame count once; hits during flash are discarded.
- On each tick in HOVER/RIGHT/LEFT, in order:
  - red counter decrements if nonzero.
  - If latch set: life-=1 (never below 0), red counter=RED_FRAMES. If new life=0 -> DYING; position frozen from this tick.
  - Else direction: if r<CHANCE_TO_CHANGE, HOVER -> RIGHT if r<CHANCE_TO_CHANGE/2 else LEFT; RIGHT/LEFT -> HOVER.
  - X: RIGHT adds step, LEFT subtracts; result clamped to [0, (SCREEN_WIDTH-IMAGE_WIDTH)<<FRAC_BITS]; reaching a clamp bound reverses RIGHT<->LEFT. Direction change and wall reversal on the same tick: wall reversal wins.
  - Y (VERTICAL_EN=1, all three states): ±(step>>1) by y direction, clamped to [Y_MIN, Y_MAX]<<FRAC_BITS, direction flips on reaching a bound.
  - Wing toggles every WING_FRAMES ticks (free-running frame counter).
- DYING: position and wing frozen; red counter decrements each tick; when it reaches 0 -> IDLE.
- alive = state≠IDLE. red = red counter≠0. coordinate = fixed-point arithmetically shifted right by FRAC_BITS.
- Fixed-point registers are 32-bit signed; speed sampled on the tick.

## Timing
- All state updates occur at the clk edge where startOfFrame=1, except IDLE->HOVER (edge where deploy=1) and collision latch set (edge where collision=1).
- Outputs registered; visible the cycle after the updating edge.
- deploy and collision on the same IDLE cycle: deploy wins, collision discarded.
- Collision and tick on the same edge: hit counts in that tick.
- reset overrides all inputs, including mid-flash or in DYING.

## Test plan
- Reset, then deploy with starting_life=3 -> next cycle alive=1, coordinate=(280,185), direction=0, red=0.
- speed=0, force r=0 on one tick -> direction=1; after 64 ticks with r≥8, x=280+(64*50)>>6=330.
- speed=3, bird in RIGHT, run to wall -> x clamps at 608, then direction=2 and x decreases next tick.
- Three collision pulses in one frame, life=3 -> life=2, red=1 for 32 ticks; collision during flash -> life unchanged.
- starting_life=1, collision -> DYING, coordinate frozen, alive=1 for 32 ticks, then alive=0, red=0; deploy afterwards respawns at (280,185).
- Assert reset mid-DYING -> next cycle alive=0, red=0, coordinate=(280,185).
